// File: rtl/gpio_pin_ctrl.sv
`default_nettype none
// gpio_pin_ctrl: registered pad drive, 2-flop sync, tick-based glitch filter, edge IRQ.
// Revision: 1.0

module gpio_pin_ctrl #(
  parameter int PRESCALE   = 100,
  parameter int FILTER_LEN = 3,
  parameter int IRQ_EDGE   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rf_gpio_datareg,
  input  logic [15:0] rf_gpio_tristate,
  input  logic [15:0] rf_gpio_interrupt_mask,
  input  logic [15:0] pad_in,
  input  logic [15:0] irq_clr,
  output logic [15:0] pad_out,
  output logic [15:0] pad_oe,
  output logic [15:0] ro_gpio_pinstate,
  output logic [15:0] irq_pending,
  output logic        irq
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [3:0]  CNT_MAX = 4'(FILTER_LEN - 1);

  logic [15:0] pad_out_q, pad_out_d;
  logic [15:0] pad_oe_q, pad_oe_d;
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;
  logic [15:0] pre_q, pre_d;
  logic [3:0]  cnt_q [16];
  logic [3:0]  cnt_d [16];
  logic [15:0] flt_q, flt_d;
  logic [15:0] flt_prev_q, flt_prev_d;
  logic [15:0] evt_q, evt_d;
  logic [15:0] pending_q, pending_d;
  logic        irq_q, irq_d;

  logic        tick;
  logic [15:0] rise, fall, edge_sel;

  always_comb begin
    pad_out_d = rf_gpio_datareg;
    pad_oe_d  = rf_gpio_tristate;
    sync1_d   = pad_in;
    sync2_d   = sync1_q;

    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? 16'd0 : pre_q + 16'd1;

    flt_d = flt_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == flt_q[i]) begin
          cnt_d[i] = 4'd0;
        end else if (cnt_q[i] == CNT_MAX) begin
          flt_d[i] = sync2_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end

    // Edges are detected on the registered filter output, so evt lands one cycle after flt moves.
    flt_prev_d = flt_q;
    rise       = flt_q & ~flt_prev_q;
    fall       = ~flt_q & flt_prev_q;
    case (IRQ_EDGE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
    evt_d = edge_sel & rf_gpio_interrupt_mask;

    // A new event wins over a clear strobe in the same cycle.
    pending_d = evt_q | (pending_q & ~irq_clr);
    irq_d     = |pending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pad_out_q  <= '0;
      pad_oe_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      pre_q      <= '0;
      flt_q      <= '0;
      flt_prev_q <= '0;
      evt_q      <= '0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pre_q      <= pre_d;
      flt_q      <= flt_d;
      flt_prev_q <= flt_prev_d;
      evt_q      <= evt_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pad_out          = pad_out_q;
  assign pad_oe           = pad_oe_q;
  assign ro_gpio_pinstate = flt_q;
  assign irq_pending      = pending_q;
  assign irq              = irq_q;

endmodule

`default_nettype wire

// File: doc/gpio_pin_ctrl.md
# gpio_pin_ctrl

Pad-side GPIO stage that sits directly downstream of the GPIO register file. It turns the register file's data, drive-enable and interrupt-mask words into registered pad drive signals. It also returns synchronized, glitch-filtered pin state to the register file's read-only pin-state input, and raises a level interrupt on qualifying pin edges.

## Interface
- PRESCALE, 100: clk cycles per filter sample tick; legal range 1..65535; 1 = tick every cycle
- FILTER_LEN, 3: consecutive differing ticks required to accept a new pin level; legal range 1..15
- IRQ_EDGE, 2: edge that sets pending; 0 = rising, 1 = falling, 2 = both
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- rf_gpio_datareg  in  16  output level per pin
- rf_gpio_tristate  in  16  per-pin driver enable; 1 = drive pad, 0 = high-Z/input
- rf_gpio_interrupt_mask  in  16  per-pin interrupt enable; 1 = enabled
- pad_in  in  16  raw pad inputs, asynchronous to clk
- irq_clr  in  16  per-pin single-cycle clear strobe for pending bits
- pad_out  out  16  registered pad output level
- pad_oe  out  16  registered pad output enable
- ro_gpio_pinstate  out  16  filtered pin state, feeds the register-file read path
- irq_pending  out  16  sticky per-pin interrupt pending
- irq  out  1  registered OR of irq_pending

## Operation
- Drive path:
  - pad_out <= rf_gpio_datareg and pad_oe <= rf_gpio_tristate, both every cycle.
  - No gating by the filter or by interrupt logic.
- Synchronizer:
  - Two flops per pin: sync1 <= pad_in, sync2 <= sync1.
  - Only sync2 is used downstream.
- Prescaler:
  - Counter 0..PRESCALE-1; wraps to 0.
  - tick = 1 in the cycle where count == PRESCALE-1.
- Filter, per pin:
  - State: 4-bit count cnt[i] and filtered level flt[i].
  - On tick, if sync2[i] == flt[i]: cnt[i] <= 0.
  - On tick, if sync2[i] != flt[i] and cnt[i] == FILTER_LEN-1: flt[i] <= sync2[i] and cnt[i] <= 0.
  - On tick, in all other differing cases: cnt[i] <= cnt[i]+1.
  - No tick: hold.
- Output of the filter: ro_gpio_pinstate = flt, registered. The filtered level is read back regardless of drive enable, so driven pins loop back through the pad.
- Edge event:
  - Per pin, evt[i] <= (flt update this cycle) and edge type matches IRQ_EDGE and rf_gpio_interrupt_mask[i].
  - Registered one cycle after flt changes.
- Pending, per bit:
  - irq_pending[i] <= evt[i] | (irq_pending[i] & ~irq_clr[i]).
  - Set wins over a simultaneous clear.
  - Clearing the mask does not clear pending bits already set.
- Interrupt: irq <= |irq_pending.

## Timing
- Reset values, all zero: pad_out, pad_oe, ro_gpio_pinstate, irq_pending, irq, sync1, sync2, cnt, prescaler, evt.
- Register change to pad_out/pad_oe: 1 cycle.
- Pad edge to ro_gpio_pinstate change:
  - Bounds: 2 + (FILTER_LEN-1)*PRESCALE + 1 minimum, 2 + FILTER_LEN*PRESCALE maximum.
  - Example, PRESCALE=4 and FILTER_LEN=3: 11..14 cycles.
- ro_gpio_pinstate change to irq_pending set: +2 cycles. irq follows 1 cycle after that.
- irq_clr strobe to irq_pending bit low: 1 cycle. irq low 1 cycle later if no other bit is pending.
- Glitch rejection: a level held for fewer than FILTER_LEN consecutive ticks never reaches flt.
- PRESCALE=1, FILTER_LEN=1: pin-state latency is exactly 3 cycles.
- Reset mid-filter: counters and flt return to 0; a pad already high is re-accepted through the normal filter latency after reset release and raises a rising edge event if the mask allows.
- All 16 pins are independent; simultaneous events on multiple pins each set their own pending bit in the same cycle.

## Test plan
- Reset, then datareg=16'hA5A5, tristate=16'h00FF:
  - pad_out=16'hA5A5 and pad_oe=16'h00FF one cycle later.
  - All other outputs 0.
- PRESCALE=4, FILTER_LEN=3; pad_in[3] 0→1 held high:
  - ro_gpio_pinstate[3] rises 11..14 cycles after the edge.
  - Other bits stay 0.
- Same parameters, pad_in[5] high for 5 cycles, then low:
  - ro_gpio_pinstate[5] never changes.
  - irq stays 0.
- IRQ_EDGE=0, mask=16'h0001, rising edges on pad_in[0] and pad_in[1] together:
  - Only irq_pending[0] sets, 2 cycles after pinstate[0] rises.
  - irq=1 one cycle later.
- irq_pending[0]=1, pulse irq_clr[0] in the same cycle a new rising event on pin 0 sets pending:
  - irq_pending[0] stays 1.
  - A later clear alone drops it, and irq deasserts 1 cycle after.
- pad_in=16'hFFFF held, assert reset for 3 cycles mid-filter:
  - All outputs 0 during reset.
  - After release, pinstate returns to 16'hFFFF within the latency bound.
  - With mask=16'hFFFF and IRQ_EDGE=0, irq_pending=16'hFFFF.
